// File: rtl/hs_rr_stream_arbiter.sv
// hs_rr_stream_arbiter
// Merges NUM_REQ valid/ready byte streams onto one registered output stream.
// Round-robin grant that is held for bursts of up to MAX_BURST beats. The output
// stage and its one-entry skid buffer are registered, so valid_o, data_o,
// grant_id_o and every ready_o bit are driven directly by flops.
//
// Handshake rule (every port): a beat moves on a rising clk edge when valid and
// ready are both 1. ready_o is never a function of ready_i in the same cycle.
// It is precomputed from next-state values and registered, and it equals
// "granted and skid empty".
module hs_rr_stream_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  output logic [NUM_REQ-1:0]        ready_o,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         data_o,
  output logic [ID_W-1:0]           grant_id_o,
  input  logic                      ready_i
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Registered state
  state_t              r_state;
  logic [ID_W-1:0]     r_cur_grant;
  logic [ID_W-1:0]     r_last_grant;
  logic [7:0]          r_beat_cnt;
  logic                r_skid_full;
  logic [DATA_W-1:0]   r_skid_data;
  logic [ID_W-1:0]     r_skid_id;
  logic                r_valid_o;
  logic [DATA_W-1:0]   r_data_o;
  logic [ID_W-1:0]     r_grant_id_o;
  logic [NUM_REQ-1:0]  r_ready_o;

  // Next-state values
  state_t              w_state_nxt;
  logic [ID_W-1:0]     w_cur_grant_nxt;
  logic [ID_W-1:0]     w_last_grant_nxt;
  logic [7:0]          w_beat_cnt_nxt;
  logic                w_skid_full_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [ID_W-1:0]     w_skid_id_nxt;
  logic                w_valid_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic [ID_W-1:0]     w_grant_id_nxt;
  logic [NUM_REQ-1:0]  w_ready_nxt;

  // Combinational helpers
  logic                w_accept;
  logic                w_out_free;
  logic                w_cur_valid;
  logic                w_cur_ready;
  logic [DATA_W-1:0]   w_beat;
  logic                w_rr_found;
  logic [ID_W-1:0]     w_rr_pick;

  assign w_accept    = |(valid_i & r_ready_o);
  assign w_out_free  = !r_valid_o || ready_i;
  assign w_cur_valid = valid_i[r_cur_grant];
  assign w_cur_ready = r_ready_o[r_cur_grant];
  assign w_beat      = data_i[int'(r_cur_grant)*DATA_W +: DATA_W];

  assign ready_o    = r_ready_o;
  assign valid_o    = r_valid_o;
  assign data_o     = r_data_o;
  assign grant_id_o = r_grant_id_o;

  // Round-robin pick: first valid requester after last_grant, wrapping around
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = r_last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(r_last_grant) + i) % NUM_REQ;
      if (!w_rr_found && valid_i[idx]) begin
        w_rr_found = 1'b1;
        w_rr_pick  = ID_W'(idx);
      end
    end
  end

  // Grant FSM next state: burst ends on MAX_BURST beats or on release
  always_comb begin
    w_state_nxt      = r_state;
    w_cur_grant_nxt  = r_cur_grant;
    w_last_grant_nxt = r_last_grant;
    w_beat_cnt_nxt   = r_beat_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_rr_found) begin
          w_cur_grant_nxt  = w_rr_pick;
          w_last_grant_nxt = w_rr_pick;
          w_beat_cnt_nxt   = 8'd0;
          w_state_nxt      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + 8'd1;
          if (w_beat_cnt_nxt == 8'(MAX_BURST)) begin
            w_state_nxt = ST_IDLE;
          end
        end
        // Ready offered but the requester had nothing: treat as release.
        // A valid drop while ready is low (skid full) keeps the grant.
        if (w_cur_ready && !w_cur_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Output register and skid buffer next values
  always_comb begin
    w_valid_nxt     = r_valid_o;
    w_data_nxt      = r_data_o;
    w_grant_id_nxt  = r_grant_id_o;
    w_skid_full_nxt = r_skid_full;
    w_skid_data_nxt = r_skid_data;
    w_skid_id_nxt   = r_skid_id;
    if (w_out_free) begin
      if (r_skid_full) begin
        // ready_o was low, so no new beat can be arriving this cycle
        w_valid_nxt     = 1'b1;
        w_data_nxt      = r_skid_data;
        w_grant_id_nxt  = r_skid_id;
        w_skid_full_nxt = 1'b0;
      end else if (w_accept) begin
        w_valid_nxt    = 1'b1;
        w_data_nxt     = w_beat;
        w_grant_id_nxt = r_cur_grant;
      end else begin
        w_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_full_nxt = 1'b1;
      w_skid_data_nxt = w_beat;
      w_skid_id_nxt   = r_cur_grant;
    end
  end

  // Registered ready: next cycle's "granted and skid empty"
  always_comb begin
    w_ready_nxt = '0;
    if (w_state_nxt == ST_GRANT && !w_skid_full_nxt) begin
      w_ready_nxt = NUM_REQ'(1) << w_cur_grant_nxt;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_cur_grant  <= '0;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_beat_cnt   <= 8'd0;
      r_skid_full  <= 1'b0;
      r_skid_data  <= '0;
      r_skid_id    <= '0;
      r_valid_o    <= 1'b0;
      r_data_o     <= '0;
      r_grant_id_o <= '0;
      r_ready_o    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_grant  <= w_cur_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_skid_full  <= w_skid_full_nxt;
      r_skid_data  <= w_skid_data_nxt;
      r_skid_id    <= w_skid_id_nxt;
      r_valid_o    <= w_valid_nxt;
      r_data_o     <= w_data_nxt;
      r_grant_id_o <= w_grant_id_nxt;
      r_ready_o    <= w_ready_nxt;
    end
  end

endmodule

// File: tb/tb_hs_rr_stream_arbiter.sv
// Directed bench for hs_rr_stream_arbiter: per-requester source FIFOs drive the
// inputs, and an expected queue of {grant_id, data} checks every output beat.
module tb_hs_rr_stream_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;
  localparam int W         = ID_W + DATA_W;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        valid_i = '0;
  logic [NUM_REQ*DATA_W-1:0] data_i = '0;
  logic [NUM_REQ-1:0]        ready_o;
  logic                      valid_o;
  logic [DATA_W-1:0]         data_o;
  logic [ID_W-1:0]           grant_id_o;
  logic                      ready_i = 1'b1;

  hs_rr_stream_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .data_i(data_i),
    .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .grant_id_o(grant_id_o), .ready_i(ready_i)
  );

  // Source FIFOs, scoreboard, counters
  logic [DATA_W-1:0] src_mem [NUM_REQ][16];
  int src_rd  [NUM_REQ];
  int src_cnt [NUM_REQ];
  logic [W-1:0] exp_q[$];
  int out_cyc[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int exp_gap [7] = '{1, 1, 1, 2, 1, 1, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_src(input int k, input logic [DATA_W-1:0] d);
    src_mem[k][src_cnt[k]] = d;
    src_cnt[k]++;
  endtask

  task automatic push_exp(input int k, input logic [DATA_W-1:0] d);
    exp_q.push_back({ID_W'(k), d});
  endtask

  // Present the head of each source FIFO
  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      if (src_rd[k] < src_cnt[k]) begin
        valid_i[k] = 1'b1;
        data_i[k*DATA_W +: DATA_W] = src_mem[k][src_rd[k]];
      end else begin
        valid_i[k] = 1'b0;
        data_i[k*DATA_W +: DATA_W] = '0;
      end
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NUM_REQ; k++) begin
      src_rd[k]  = 0;
      src_cnt[k] = 0;
    end
    exp_q.delete();
    out_cyc.delete();
  endtask

  // One clock: sample handshakes at negedge, apply them after the edge
  task automatic tick();
    logic [NUM_REQ-1:0] hs;
    logic               out_hs;
    logic [W-1:0]       out_word;
    logic [W-1:0]       e;
    @(negedge clk);
    hs       = valid_i & ready_o;
    out_hs   = valid_o & ready_i;
    out_word = {grant_id_o, data_o};
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (hs[k]) src_rd[k]++;
    end
    if (out_hs) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'(out_word), 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("beat", 32'(out_word), 32'(e));
      end
    end
    cyc++;
    drive();
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_all();
    ready_i = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values and idle behaviour
    do_reset();
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_ready_o", 32'(ready_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_grant_id", 32'(grant_id_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_valid_o", 32'(valid_o), 32'd0);
      check("idle_ready_o", 32'(ready_o), 32'd0);
    end

    // Lone requester 1: two bursts of 4 with one gap cycle
    do_reset();
    for (int n = 0; n < 8; n++) begin
      push_src(1, DATA_W'(8'h10 + n));
      push_exp(1, DATA_W'(8'h10 + n));
    end
    drive();
    drain(40);
    check("t1_count", 32'(out_cyc.size()), 32'd8);
    if (out_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) begin
        check("t1_gap", 32'(out_cyc[i] - out_cyc[i-1]), 32'(exp_gap[i-1]));
      end
    end

    // All four requesters busy: rotation 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int n = 0; n < 8; n++) push_src(k, DATA_W'(k*16 + n));
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        for (int n = 0; n < 4; n++) push_exp(k, DATA_W'(k*16 + r*4 + n));
      end
    end
    drive();
    drain(80);
    check("t2_count", 32'(out_cyc.size()), 32'd32);
    if (out_cyc.size() == 32) begin
      check("t2_span", 32'(out_cyc[31] - out_cyc[0]), 32'd38);
    end

    // Downstream stall with skid capture on requester 2
    do_reset();
    push_src(2, 8'hA0); push_src(2, 8'hA1); push_src(2, 8'hA2);
    push_exp(2, 8'hA0); push_exp(2, 8'hA1); push_exp(2, 8'hA2);
    ready_i = 1'b0;
    drive();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_valid", 32'(valid_o), 32'd1);
      check("t3_stall_data", 32'(data_o), 32'hA0);
      check("t3_stall_id", 32'(grant_id_o), 32'd2);
      check("t3_stall_ready", 32'(ready_o), 32'd0);
      if (i < 2) tick();
    end
    ready_i = 1'b1;
    tick();
    check("t3_skid_data", 32'(data_o), 32'hA1);
    check("t3_skid_id", 32'(grant_id_o), 32'd2);
    check("t3_ready_back", 32'(ready_o), 32'b0100);
    drain(20);

    // Requester 0 releases after 2 beats, requester 3 follows
    do_reset();
    push_src(0, 8'h01); push_src(0, 8'h02);
    push_src(3, 8'h31); push_src(3, 8'h32);
    push_exp(0, 8'h01); push_exp(0, 8'h02);
    push_exp(3, 8'h31); push_exp(3, 8'h32);
    drive();
    drain(30);
    check("t4_count", 32'(out_cyc.size()), 32'd4);
    if (out_cyc.size() == 4) begin
      check("t4_release_gap", 32'(out_cyc[2] - out_cyc[1]), 32'd3);
    end

    // Asynchronous reset with the skid full
    do_reset();
    push_src(2, 8'hA0); push_src(2, 8'hA1); push_src(2, 8'hA2);
    ready_i = 1'b0;
    drive();
    repeat (3) tick();
    check("t5_pre_ready", 32'(ready_o), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(valid_o), 32'd0);
    check("t5_async_ready", 32'(ready_o), 32'd0);
    check("t5_async_data", 32'(data_o), 32'd0);
    clear_all();
    ready_i = 1'b1;
    drive();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    push_src(1, 8'h51); push_src(0, 8'h41);
    push_exp(0, 8'h41); push_exp(1, 8'h51);
    drive();
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
